// File: rtl/inv_chain_monitor.sv
// Clocked checker for the prsim inverter chain: synchronizes the chain input and taps,
// checks tap polarity, measures input-edge to full-chain-match latency and counts faults.
module inv_chain_monitor #(
  parameter int NTAPS         = 5,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 16,
  parameter int LAT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             chain_in,
  input  logic [NTAPS-1:0] taps,
  output logic             meas_valid,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

  localparam logic [LAT_W-1:0] SETTLE_LAT = LAT_W'(SETTLE_CYCLES);
  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);

  state_t           state;
  logic             s1_in, s_in, prev_in;
  logic [NTAPS-1:0] s1_taps, s_taps, exp_taps;
  logic [LAT_W-1:0] lat;
  logic             match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Even taps sit after an odd number of inverters, so they carry the inverted input.
  always_comb begin
    exp_taps = '0;
    for (int unsigned k = 0; k < NTAPS; k++)
      exp_taps[k] = (k % 2 == 0) ? ~s_in : s_in;
  end

  assign match = (s_taps == exp_taps);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_in      <= 1'b0;
      s_in       <= 1'b0;
      s1_taps    <= '0;
      s_taps     <= '0;
      prev_in    <= 1'b0;
      lat        <= '0;
      state      <= IDLE;
      meas_valid <= 1'b0;
      last_lat   <= '0;
      max_lat    <= '0;
      edge_cnt   <= '0;
      err_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      s1_in      <= chain_in;
      s_in       <= s1_in;
      s1_taps    <= taps;
      s_taps     <= s1_taps;
      meas_valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            prev_in <= s_in;
            state   <= ARMED;
          end
          ARMED: begin
            if (s_in != prev_in) begin
              prev_in <= s_in;
              lat     <= LAT_ONE;
              state   <= MEASURE;
            end else if (!match) begin
              err_cnt <= sat_inc(err_cnt);
              err     <= 1'b1;
            end
          end
          MEASURE: begin
            if (s_in != prev_in) begin
              prev_in <= s_in;
              lat     <= LAT_ONE;
              err_cnt <= sat_inc(err_cnt);
              err     <= 1'b1;
            end else if (match) begin
              last_lat   <= lat;
              if (lat > max_lat) max_lat <= lat;
              edge_cnt   <= sat_inc(edge_cnt);
              meas_valid <= 1'b1;
              state      <= ARMED;
            end else if (lat == SETTLE_LAT) begin
              err_cnt <= sat_inc(err_cnt);
              err     <= 1'b1;
              state   <= ARMED;
            end else begin
              lat <= lat + LAT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inv_chain_monitor.sv
// Self-checking bench for inv_chain_monitor: event-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_inv_chain_monitor;

  localparam int NTAPS  = 5;
  localparam int SETTLE = 8;
  localparam int LAT_W  = 8;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             chain_in = 1'b0;
  logic [NTAPS-1:0] taps = 5'b10101;

  logic             meas_valid, err;
  logic [LAT_W-1:0] last_lat, max_lat;
  logic [CNT_W-1:0] edge_cnt, err_cnt;

  logic             s_meas_valid, s_err;
  logic [LAT_W-1:0] s_last_lat, s_max_lat;
  logic [SAT_W-1:0] s_edge_cnt, s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_chain_monitor #(.NTAPS(NTAPS), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .chain_in(chain_in), .taps(taps),
    .meas_valid(meas_valid), .last_lat(last_lat), .max_lat(max_lat),
    .edge_cnt(edge_cnt), .err_cnt(err_cnt), .err(err));

  // Narrow-counter instance on the same stimulus, to reach saturation quickly.
  inv_chain_monitor #(.NTAPS(NTAPS), .SETTLE_CYCLES(SETTLE), .CNT_W(SAT_W), .LAT_W(LAT_W)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .chain_in(chain_in), .taps(taps),
    .meas_valid(s_meas_valid), .last_lat(s_last_lat), .max_lat(s_max_lat),
    .edge_cnt(s_edge_cnt), .err_cnt(s_err_cnt), .err(s_err));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: tracks what has happened (edge seen at cycle N, event totals)
  // and derives outputs from that; raw inputs reach it two samples late.
  int         m_cyc = 0, m_start = 0, m_mode = 0;   // 0 idle, 1 waiting for edge, 2 timing
  int         m_last = 0, m_max = 0, m_edges = 0, m_errs = 0;
  bit         m_mv = 0, m_prev = 0, started = 0;
  bit         hin[2];
  logic [4:0] htaps[2];

  always @(posedge clk) begin
    bit         si, mt;
    logic [4:0] st, ex;
    si = hin[1];
    st = htaps[1];
    if (reset) begin
      m_mode = 0; m_last = 0; m_max = 0; m_edges = 0; m_errs = 0; m_mv = 0; m_prev = 0;
      hin[0] = 0; hin[1] = 0; htaps[0] = '0; htaps[1] = '0;
      started = 1;
    end else begin
      for (int k = 0; k < NTAPS; k++) ex[k] = (k % 2 == 0) ? !si : si;
      mt = (st == ex);
      m_mv = 0;
      if (!enable) m_mode = 0;
      else if (m_mode == 0) begin
        m_prev = si; m_mode = 1;
      end else if (m_mode == 1) begin
        if (si != m_prev) begin m_prev = si; m_start = m_cyc; m_mode = 2; end
        else if (!mt) m_errs++;
      end else begin
        if (si != m_prev) begin m_prev = si; m_start = m_cyc; m_errs++; end
        else if (mt) begin
          m_last = m_cyc - m_start;
          if (m_last > m_max) m_max = m_last;
          m_edges++; m_mv = 1; m_mode = 1;
        end else if (m_cyc - m_start == SETTLE) begin
          m_errs++; m_mode = 1;
        end
      end
      hin[1] = hin[0]; hin[0] = chain_in;
      htaps[1] = htaps[0]; htaps[0] = taps;
    end
    m_cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("meas_valid", int'(meas_valid), int'(m_mv));
      chk("last_lat", int'(last_lat), m_last);
      chk("max_lat", int'(max_lat), m_max);
      chk("edge_cnt", int'(edge_cnt), sat(m_edges, CNT_W));
      chk("err_cnt", int'(err_cnt), sat(m_errs, CNT_W));
      chk("err", int'(err), int'(m_errs != 0));
      chk("sat_edge_cnt", int'(s_edge_cnt), sat(m_edges, SAT_W));
      chk("sat_err_cnt", int'(s_err_cnt), sat(m_errs, SAT_W));
      chk("sat_err", int'(s_err), int'(m_errs != 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; chain_in = 1'b0; taps = 5'b10101;
    tick(2);
    chk("rst_last_lat", int'(last_lat), 0);
    chk("rst_edge_cnt", int'(edge_cnt), 0);
    reset = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(1);
  endtask

  task automatic wait_mv(input string name, input int budget);
    int n = 0;
    while (!meas_valid && n < budget) begin tick(1); n++; end
    chk({name, "_mv_seen"}, int'(meas_valid), 1);
  endtask

  task automatic wait_err(input string name, input int budget);
    int n = 0;
    while (err_cnt == 0 && n < budget) begin tick(1); n++; end
    chk({name, "_err_seen"}, int'(err_cnt != 0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    tick(1);
    // 1: steady, correct polarity
    do_reset();
    tick(20);
    chk("t1_err_cnt", int'(err_cnt), 0);
    chk("t1_err", int'(err), 0);
    chk("t1_edge_cnt", int'(edge_cnt), 0);

    // 2: taps follow one per cycle, starting 3 cycles after the edge
    chain_in = 1'b1;
    tick(3);
    for (int k = 0; k < NTAPS; k++) begin taps[k] = ~taps[k]; tick(1); end
    wait_mv("t2", 12);
    chk("t2_last_lat", int'(last_lat), 7);
    chk("t2_edge_cnt", int'(edge_cnt), 1);
    chk("t2_err", int'(err), 0);
    tick(1);
    chk("t2_mv_once", int'(meas_valid), 0);

    // 3: taps frozen -> timeout
    do_reset();
    chain_in = 1'b1;
    wait_err("t3", 20);
    chk("t3_err_cnt", int'(err_cnt), 1);
    chk("t3_err", int'(err), 1);
    chk("t3_edge_cnt", int'(edge_cnt), 0);
    taps = 5'b01010;
    tick(5);

    // 4: second edge before settle -> overrun, latency from second edge
    do_reset();
    chain_in = 1'b1;
    tick(1);
    taps = 5'b10100;
    tick(2);
    chain_in = 1'b0;
    tick(4);
    taps = 5'b10101;
    wait_mv("t4", 12);
    chk("t4_err_cnt", int'(err_cnt), 1);
    chk("t4_edge_cnt", int'(edge_cnt), 1);
    chk("t4_last_lat", int'(last_lat), 4);

    // 5: 3-cycle glitch on taps[2], then an all-at-once edge
    do_reset();
    tick(2);
    taps[2] = ~taps[2];
    tick(3);
    taps[2] = ~taps[2];
    tick(4);
    chk("t5_err_cnt", int'(err_cnt), 3);
    chk("t5_edge_cnt", int'(edge_cnt), 0);
    chain_in = 1'b1;
    taps = 5'b01010;
    wait_mv("t5", 8);
    chk("t5_last_lat", int'(last_lat), 1);
    chk("t5_edge_cnt2", int'(edge_cnt), 1);

    // 7: disable mid-measurement discards it
    chain_in = 1'b0;
    tick(4);
    enable = 1'b0;
    taps = 5'b10101;
    tick(4);
    enable = 1'b1;
    tick(6);
    chk("t7_edge_cnt", int'(edge_cnt), 1);
    chk("t7_err_cnt", int'(err_cnt), 3);

    // 6: saturation on the narrow instance, then reset mid-measure
    do_reset();
    for (int i = 0; i < 9; i++) begin
      chain_in = ~chain_in;
      taps = ~taps;
      wait_mv("t6", 8);
      tick(2);
    end
    chk("t6_edge_cnt", int'(edge_cnt), 9);
    chk("t6_sat_edge_cnt", int'(s_edge_cnt), 7);
    taps[0] = ~taps[0];
    tick(10);
    taps[0] = ~taps[0];
    tick(4);
    chk("t6_err_cnt", int'(err_cnt), 10);
    chk("t6_sat_err_cnt", int'(s_err_cnt), 7);
    chain_in = ~chain_in;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_mv", int'(meas_valid), 0);
    chk("t6_rst_last", int'(last_lat), 0);
    chk("t6_rst_max", int'(max_lat), 0);
    chk("t6_rst_edge", int'(edge_cnt), 0);
    chk("t6_rst_errc", int'(err_cnt), 0);
    chk("t6_rst_err", int'(err), 0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
